// File: rtl/dcache_pkg.sv
// dcache_pkg: shared types and width helpers for the direct-mapped data cache.
//   state_e   - controller states (IDLE, WRITEBACK, ALLOCATE)
//   WORD_W    - CPU word width
//   offset_w / index_w / tag_w - address field widths derived from the
//               NUM_LINES / WORDS_PER_LINE parameters of the instantiating module
package dcache_pkg;

  localparam int WORD_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WRITEBACK,
    ALLOCATE
  } state_e;

  function automatic int offset_w(input int words_per_line);
    return $clog2(words_per_line);
  endfunction

  function automatic int index_w(input int num_lines);
    return $clog2(num_lines);
  endfunction

  // Two byte-offset bits sit below the word offset.
  function automatic int tag_w(input int num_lines, input int words_per_line);
    return WORD_W - index_w(num_lines) - offset_w(words_per_line) - 2;
  endfunction

endpackage

// File: rtl/dcache_array.sv
// dcache_array: storage for the direct-mapped cache.
//   clk, rst_n          - clock, async active-low reset (clears valid/dirty only)
//   idx                 - line index used for both the async read and all writes
//   rd_valid/rd_dirty/rd_tag/rd_line - combinational view of line idx
//   word_we/word_off/word_data - store one word into line idx, set dirty
//   fill_we/fill_tag/fill_line - replace line idx, valid=1, dirty=0
//   clean_we            - clear dirty of line idx after a write-back
module dcache_array
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4,
  localparam int INDEX_W  = index_w(NUM_LINES),
  localparam int OFFSET_W = offset_w(WORDS_PER_LINE),
  localparam int TAG_W    = tag_w(NUM_LINES, WORDS_PER_LINE),
  localparam int LINE_W   = WORD_W * WORDS_PER_LINE
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [INDEX_W-1:0]  idx,
  output logic                rd_valid,
  output logic                rd_dirty,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [LINE_W-1:0]   rd_line,
  input  logic                word_we,
  input  logic [OFFSET_W-1:0] word_off,
  input  logic [WORD_W-1:0]   word_data,
  input  logic                fill_we,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_line,
  input  logic                clean_we
);

  logic [NUM_LINES-1:0] valid_q;
  logic [NUM_LINES-1:0] dirty_q;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (fill_we) begin
      valid_q[idx] <= 1'b1;
      dirty_q[idx] <= 1'b0;
    end else if (word_we) begin
      dirty_q[idx] <= 1'b1;
    end else if (clean_we) begin
      dirty_q[idx] <= 1'b0;
    end
  end

  // NOTE: tag and data arrays are deliberately not reset; valid gates every
  // use, so a reset here would only cost a reset net on every storage bit.
  always_ff @(posedge clk) begin
    if (fill_we) begin
      tag_q[idx]  <= fill_tag;
      data_q[idx] <= fill_line;
    end else if (word_we) begin
      data_q[idx][word_off*WORD_W +: WORD_W] <= word_data;
    end
  end

  assign rd_valid = valid_q[idx];
  assign rd_dirty = dirty_q[idx];
  assign rd_tag   = tag_q[idx];
  assign rd_line  = data_q[idx];

endmodule

// File: rtl/dcache_ctrl.sv
// dcache_ctrl: direct-mapped, write-back, write-allocate data cache controller.
//   clk_i, rst_i        - clock, async active-low reset
//   cpu_addr_i/cpu_wdata_i/cpu_read_i/cpu_write_i - CPU data port (write wins)
//   cpu_rdata_o         - load data, 0 unless a read hits in IDLE
//   cpu_stall_o         - CPU holds PC and request while high
//   mem_req_o/mem_we_o/mem_addr_o/mem_wdata_o - registered line request
//   mem_rdata_i/mem_ack_i - fill data and one-cycle completion pulse
//   hit_cnt_o/miss_cnt_o - first-try hit and miss counters (wrapping)
module dcache_ctrl
  import dcache_pkg::*;
#(
  parameter int NUM_LINES      = 16,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [31:0]                      cpu_addr_i,
  input  logic [31:0]                      cpu_wdata_i,
  input  logic                             cpu_read_i,
  input  logic                             cpu_write_i,
  output logic [31:0]                      cpu_rdata_o,
  output logic                             cpu_stall_o,
  output logic                             mem_req_o,
  output logic                             mem_we_o,
  output logic [31:0]                      mem_addr_o,
  output logic [WORD_W*WORDS_PER_LINE-1:0] mem_wdata_o,
  input  logic [WORD_W*WORDS_PER_LINE-1:0] mem_rdata_i,
  input  logic                             mem_ack_i,
  output logic [31:0]                      hit_cnt_o,
  output logic [31:0]                      miss_cnt_o
);

  localparam int OFFSET_W = offset_w(WORDS_PER_LINE);
  localparam int INDEX_W  = index_w(NUM_LINES);
  localparam int TAG_W    = tag_w(NUM_LINES, WORDS_PER_LINE);
  localparam int LINE_W   = WORD_W * WORDS_PER_LINE;

  logic [OFFSET_W-1:0] req_off;
  logic [INDEX_W-1:0]  req_idx;
  logic [TAG_W-1:0]    req_tag;
  logic                unused_addr_bits;

  assign req_off          = cpu_addr_i[2 +: OFFSET_W];
  assign req_idx          = cpu_addr_i[2+OFFSET_W +: INDEX_W];
  assign req_tag          = cpu_addr_i[WORD_W-1 -: TAG_W];
  assign unused_addr_bits = ^cpu_addr_i[1:0];

  logic              arr_valid, arr_dirty;
  logic [TAG_W-1:0]  arr_tag;
  logic [LINE_W-1:0] arr_line;
  logic              word_we, fill_we, clean_we;

  dcache_array #(
    .NUM_LINES      (NUM_LINES),
    .WORDS_PER_LINE (WORDS_PER_LINE)
  ) u_array (
    .clk       (clk_i),
    .rst_n     (rst_i),
    .idx       (req_idx),
    .rd_valid  (arr_valid),
    .rd_dirty  (arr_dirty),
    .rd_tag    (arr_tag),
    .rd_line   (arr_line),
    .word_we   (word_we),
    .word_off  (req_off),
    .word_data (cpu_wdata_i),
    .fill_we   (fill_we),
    .fill_tag  (req_tag),
    .fill_line (mem_rdata_i),
    .clean_we  (clean_we)
  );

  state_e state_q, state_d;
  logic   refill_q;
  logic   req, hit, ack, in_idle, idle_hit, idle_miss;

  assign req       = cpu_read_i | cpu_write_i;
  assign hit       = arr_valid & (arr_tag == req_tag);
  assign ack       = mem_ack_i & mem_req_o;
  assign in_idle   = (state_q == IDLE);
  assign idle_hit  = in_idle & req & hit;
  assign idle_miss = in_idle & req & ~hit;

  // NOTE: every signal driven here gets a default first, so no path through
  // the case leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d  = state_q;
    word_we  = 1'b0;
    fill_we  = 1'b0;
    clean_we = 1'b0;
    case (state_q)
      IDLE: begin
        if (idle_hit) begin
          word_we = cpu_write_i;
        end else if (idle_miss) begin
          state_d = (arr_valid & arr_dirty) ? WRITEBACK : ALLOCATE;
        end
      end
      WRITEBACK: begin
        if (ack) begin
          clean_we = 1'b1;
          state_d  = ALLOCATE;
        end
      end
      ALLOCATE: begin
        if (ack) begin
          fill_we = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign cpu_stall_o = ~in_idle | (req & ~hit);
  assign cpu_rdata_o = (cpu_read_i & idle_hit) ? arr_line[req_off*WORD_W +: WORD_W] : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Memory-side request registers: loaded on the IDLE-miss edge so they are
  // stable from the first request cycle; the write-back ack retargets them
  // to the fill of the requested line.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mem_req_o   <= 1'b0;
      mem_we_o    <= 1'b0;
      mem_addr_o  <= '0;
      mem_wdata_o <= '0;
    end else if (idle_miss) begin
      mem_req_o <= 1'b1;
      if (arr_valid & arr_dirty) begin
        mem_we_o    <= 1'b1;
        mem_addr_o  <= {arr_tag, req_idx, {(OFFSET_W+2){1'b0}}};
        mem_wdata_o <= arr_line;
      end else begin
        mem_we_o   <= 1'b0;
        mem_addr_o <= {req_tag, req_idx, {(OFFSET_W+2){1'b0}}};
      end
    end else if (state_q == WRITEBACK && ack) begin
      mem_we_o   <= 1'b0;
      mem_addr_o <= {req_tag, req_idx, {(OFFSET_W+2){1'b0}}};
    end else if (state_q == ALLOCATE && ack) begin
      mem_req_o <= 1'b0;
      mem_we_o  <= 1'b0;
    end
  end

  // The refill flag marks the replay cycle after a fill so that the hit it
  // produces is not counted as a first-try hit.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      refill_q   <= 1'b0;
      hit_cnt_o  <= '0;
      miss_cnt_o <= '0;
    end else begin
      if (idle_miss) begin
        refill_q   <= 1'b1;
        miss_cnt_o <= miss_cnt_o + 32'd1;
      end else if (in_idle) begin
        refill_q <= 1'b0;
      end
      if (idle_hit && !refill_q) begin
        hit_cnt_o <= hit_cnt_o + 32'd1;
      end
    end
  end

endmodule
